// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped, write-through, no-write-allocate data-cache controller.
// Define CACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module dcache_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_DONE} state_t;

  state_t state, state_nx;

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tags  [LINES];
  logic [DATA_WIDTH-1:0] lines [LINES];
  logic [DATA_WIDTH-1:0] fill;

  logic [INDEX_WIDTH-1:0] req_idx, mem_idx;
  logic [TAG_W-1:0]       req_tag, mem_tag;
  logic                   req_hit, mem_hit, handshake;
  logic                   start_rd, start_wr, do_flush, do_fill, do_wr_hit, ld_hit;
  logic [1:0]             unused_lsb;

  assign unused_lsb = req_addr[1:0];
  assign req_idx    = req_addr[INDEX_WIDTH+1:2];
  assign req_tag    = req_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  // Transactions in flight index the array through the registered address.
  assign mem_idx    = mem_addr[INDEX_WIDTH+1:2];
  assign mem_tag    = mem_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
  assign req_hit    = valid[req_idx] && (tags[req_idx] == req_tag);
  assign mem_hit    = valid[mem_idx] && (tags[mem_idx] == mem_tag);
  assign handshake  = mem_req_valid && mem_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    rdata     = '0;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    do_flush  = 1'b0;
    do_fill   = 1'b0;
    do_wr_hit = 1'b0;
    ld_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          if (req_we) begin
            stall    = 1'b1;
            start_wr = 1'b1;
            state_nx = S_WR_REQ;
          end else if (req_hit) begin
            rdata  = lines[req_idx];
            ld_hit = 1'b1;
          end else begin
            stall    = 1'b1;
            start_rd = 1'b1;
            state_nx = S_RD_REQ;
          end
        end else if (flush) begin
          do_flush = 1'b1;
        end
      end
      S_RD_REQ: begin
        stall = 1'b1;
        if (handshake) state_nx = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        stall = 1'b1;
        if (mem_rsp_valid) begin
          do_fill  = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_WR_REQ: begin
        stall = 1'b1;
        if (handshake) begin
          do_wr_hit = mem_hit;
          state_nx  = S_DONE;
        end
      end
      S_DONE: begin
        if (!mem_we) rdata = fill;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      valid         <= '0;
      fill          <= '0;
    end else begin
      if (start_rd || start_wr) begin
        mem_req_valid <= 1'b1;
        mem_we        <= start_wr;
        mem_addr      <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata     <= start_wr ? req_wdata : mem_wdata;
      end else if (handshake) begin
        mem_req_valid <= 1'b0;
      end
      if (do_flush) valid <= '0;
      else if (do_fill) valid[mem_idx] <= 1'b1;
      if (do_fill) fill <= mem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_fill) begin
      tags[mem_idx]  <= mem_tag;
      lines[mem_idx] <= mem_rsp_data;
    end else if (do_wr_hit) begin
      lines[mem_idx] <= mem_wdata;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (ld_hit)   hit_cnt  <= hit_cnt + 32'd1;
      if (start_rd) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed and randomized checks of dcache_ctrl against an address-level cache model.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, flush = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        mem_req_valid, mem_we;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rsp_data = '0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rdata(rdata), .stall(stall),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  // Model: backing memory by word address, and per-line resident address/data.
  logic [31:0] mem_m [logic [31:0]];
  bit          c_v    [8];
  logic [31:0] c_addr [8];
  logic [31:0] c_data [8];
  int          hits = 0, misses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk_stats();
`ifdef CACHE_STATS_EN
    chk("hit_cnt", hit_cnt, hits);
    chk("miss_cnt", miss_cnt, misses);
`endif
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) c_v[k] = 0;
  endtask

  // One load/store; rdly = cycles ready stays low, dly = response cycles after acceptance.
  task automatic access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                        input int rdly, input int dly);
    logic [31:0] wa, exp_data;
    int          i, exp_stall, n_stall, wait_cnt, since;
    bit          hit;
    wa        = a & ~32'h3;
    i         = int'(wa[4:2]);
    hit       = c_v[i] && (c_addr[i] == wa);
    exp_data  = hit ? c_data[i] : mem_val(wa);
    exp_stall = (!we && hit) ? 0 : (we ? rdly + 2 : rdly + 2 + dly);
    n_stall   = 0;
    wait_cnt  = 0;
    since     = -1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc > 0) @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
      if (since >= 0) since++;
      if (mem_req_valid) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, we});
        chk("mem_addr", mem_addr, wa);
        if (we) chk("mem_wdata", mem_wdata, wd);
        mem_req_ready = (wait_cnt >= rdly);
        wait_cnt++;
        if (mem_req_ready) since = 0;
      end
      if (!we && since == dly) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_val(wa);
      end
      #1;
      if (!stall) break;
      n_stall++;
      @(posedge clk);
    end
    chk("stall_cycles", n_stall, exp_stall);
    chk("done_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    if (!we) chk("rdata", rdata, exp_data);
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    if (we) begin
      mem_m[wa] = wd;
      if (hit) c_data[i] = wd;
    end else if (hit) begin
      hits++;
    end else begin
      c_v[i] = 1; c_addr[i] = wa; c_data[i] = exp_data;
      misses++;
    end
    chk_stats();
  endtask

  task automatic do_flush();
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    #1;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_stats();

    mem_m[32'h40] = 32'hDEAD_BEEF;
    access(0, 32'h40, 0, 0, 1);
    access(0, 32'h40, 0, 0, 1);
    access(0, 32'h60, 0, 0, 1);
    access(0, 32'h40, 0, 0, 1);
    access(0, 32'h60, 0, 1, 2);
    access(0, 32'h40, 0, 0, 1);
    access(1, 32'h40, 32'h1234_5678, 4, 1);
    access(0, 32'h43, 0, 0, 1);
    access(1, 32'h80, 32'hCAFE_F00D, 0, 1);
    access(0, 32'h80, 0, 0, 1);
    access(0, 32'h80, 0, 0, 1);
    do_flush();
    access(0, 32'h40, 0, 0, 1);
    access(0, 32'h40, 0, 0, 1);

    // Reset while the refill is outstanding; the late response must not land.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0; req_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("abort_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
    #1;
    chk("late_rsp_stall", {31'd0, stall}, 32'd0);
    chk("late_rsp_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    model_clear();
    hits = 0; misses = 0;
    access(0, 32'h100, 0, 0, 1);
    access(0, 32'h100, 0, 0, 1);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 1) * 32'h1000) + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) do_flush();
      access($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-through, no-write-allocate data-cache controller for the pipelined RISC-V core's MEM stage.
- Owns the tag/valid/data line array and serves load hits with zero stall.
- Runs the refill and write-through handshakes to backing data memory.
- Drives `stall` to freeze the pipeline while a miss or store is outstanding.
- Sits between the MEM stage (upstream) and the data memory (downstream).

Parameters:
- ADDR_WIDTH, 32: byte-address width.
- DATA_WIDTH, 32: word width; one word per line.
- INDEX_WIDTH, 3: line-index bits. Lines = 2**INDEX_WIDTH; index = addr[INDEX_WIDTH+1:2]; tag = addr[ADDR_WIDTH-1:INDEX_WIDTH+2] (27 bits at defaults).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage has a load/store this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  word-aligned byte address; bits [1:0] ignored.
- req_wdata  in  DATA_WIDTH  store data.
- rdata  out  DATA_WIDTH  load result; valid when req_valid & !req_we & !stall.
- stall  out  1  freeze the pipeline; request inputs must be held stable while high.
- flush  in  1  invalidate all lines; honoured only in IDLE.
- mem_req_valid  out  1  memory request valid (registered).
- mem_req_ready  in  1  memory accepts the request when valid & ready.
- mem_we  out  1  1 = write-through, 0 = refill read (registered).
- mem_addr  out  ADDR_WIDTH  word-aligned request address (registered).
- mem_wdata  out  DATA_WIDTH  write data (registered).
- mem_rsp_valid  in  1  one-cycle pulse carrying refill data.
- mem_rsp_data  in  DATA_WIDTH  refill data.

Behaviour:
Reset (rst_n low, async):
- All valid bits cleared; state = IDLE.
- mem_req_valid = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- rdata = 0 when stall is not asserted.

Hit = valid[idx] && tag[idx] == req tag, evaluated combinationally.

States: IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- IDLE
  - req_valid = 0: stall = 0.
  - Load hit: rdata = line data, stall = 0, stay in IDLE (0 stall cycles).
  - Load miss: stall = 1; register mem_req_valid = 1, mem_we = 0, mem_addr = req_addr & ~3; go to RD_REQ.
  - Store (hit or miss): stall = 1; register mem_req_valid = 1, mem_we = 1, mem_addr, mem_wdata = req_wdata; go to WR_REQ.
  - flush with no req_valid: clear all valid bits at the edge. flush together with req_valid: the request is handled and flush is ignored.
- RD_REQ: stall = 1. On mem_req_valid & mem_req_ready, drop mem_req_valid and go to RD_WAIT. Otherwise hold all mem_* outputs stable.
- RD_WAIT: stall = 1. On mem_rsp_valid, write data, tag and valid = 1 to line[idx], capture the data into a fill register, and go to DONE.
- WR_REQ: stall = 1. On handshake, drop mem_req_valid; if the store hits, update the line data in the same edge (tag/valid unchanged); go to DONE. A store miss does not allocate.
- DONE: stall = 0 for exactly one cycle; for a load, rdata = fill register. Return to IDLE; the pipeline advances this cycle.

Rules and boundaries:
- Minimum miss latency (ready = 1, response one cycle after acceptance): 3 stall cycles, then the DONE cycle.
- mem_rsp_valid outside RD_WAIT is ignored.
- mem_rsp_valid in the same cycle as acceptance in RD_REQ is ignored (the response must come later).
- flush outside IDLE is ignored.
- Reset mid-transaction aborts: mem_req_valid drops immediately; a late response is ignored because the FSM is in IDLE.
- Index aliasing: a miss evicts the resident line silently (write-through, so nothing is dirty).

Optional Feature:
CACHE_STATS_EN:
- Defined: adds outputs hit_cnt and miss_cnt (32 bits each, reset 0, wrapping at 2**32).
  - hit_cnt increments on an IDLE load hit.
  - miss_cnt increments on the IDLE→RD_REQ transition.
  - Stores are not counted.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then load 0x0000_0040 with memory returning 0xDEAD_BEEF (ready = 1, rsp one cycle later) → stall high 3 cycles, DONE rdata = 0xDEAD_BEEF; an immediate reload of 0x40 gives stall = 0 and rdata = 0xDEAD_BEEF in the same cycle.
- Load 0x40, then load 0x60 (same index 0, different tag), then load 0x40 → three misses; second refill evicts; miss_cnt = 3 when CACHE_STATS_EN.
- Store 0x1234_5678 to 0x40 while it is cached, with mem_req_ready low for 4 cycles → mem_* held stable, stall high until handshake; a later load of 0x40 hits with 0x1234_5678.
- Store to uncached 0x80 → write-through occurs; a following load of 0x80 misses (no allocate).
- Assert flush in IDLE after caching 0x40 → the next load of 0x40 misses.
- Drop rst_n in RD_WAIT, then pulse mem_rsp_valid after release → stall = 0, mem_req_valid = 0, no line written; the next load of the same address misses.
